// File: rtl/axi_memory_master.sv
// rtl/axi_memory_master.sv - single-outstanding AXI4 INCR burst initiator; optional counters under AXI_MASTER_STATS_EN
module axi_memory_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    done_valid,
  output logic                    done_write,
  output logic [1:0]              done_resp,
  output logic                    done_err,
  output logic [ID_WIDTH-1:0]     M_AXI_awid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [7:0]              M_AXI_awlen,
  output logic [2:0]              M_AXI_awsize,
  output logic [1:0]              M_AXI_awburst,
  output logic                    M_AXI_awlock,
  output logic [3:0]              M_AXI_awcache,
  output logic [2:0]              M_AXI_awprot,
  output logic [3:0]              M_AXI_awqos,
  output logic [3:0]              M_AXI_awregion,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wlast,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  input  logic [ID_WIDTH-1:0]     M_AXI_bid,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  output logic [ID_WIDTH-1:0]     M_AXI_arid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [7:0]              M_AXI_arlen,
  output logic [2:0]              M_AXI_arsize,
  output logic [1:0]              M_AXI_arburst,
  output logic                    M_AXI_arlock,
  output logic [3:0]              M_AXI_arcache,
  output logic [2:0]              M_AXI_arprot,
  output logic [3:0]              M_AXI_arqos,
  output logic [3:0]              M_AXI_arregion,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  input  logic [ID_WIDTH-1:0]     M_AXI_rid,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rlast,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready
`ifdef AXI_MASTER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]   stat_wr_bursts,
  output logic [STAT_WIDTH-1:0]   stat_rd_bursts,
  output logic [STAT_WIDTH-1:0]   stat_err
`endif
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  localparam logic [2:0] AX_SIZE = 3'($clog2(DATA_WIDTH/8));

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  write_q;
  logic                  aw_valid_q;
  logic                  ar_valid_q;
  logic [1:0]            resp_q;
  logic                  err_q;
  logic                  last_beat;

  // BID/RID are not checked: only one burst is ever outstanding.
  logic unused_ids;
  assign unused_ids = ^{M_AXI_bid, M_AXI_rid};

  assign last_beat = (beat_cnt == len_q);

  assign M_AXI_awid     = id_q;
  assign M_AXI_awaddr   = addr_q;
  assign M_AXI_awlen    = len_q;
  assign M_AXI_awsize   = AX_SIZE;
  assign M_AXI_awburst  = 2'b01;
  assign M_AXI_awlock   = 1'b0;
  assign M_AXI_awcache  = 4'd0;
  assign M_AXI_awprot   = 3'd0;
  assign M_AXI_awqos    = 4'd0;
  assign M_AXI_awregion = 4'd0;
  assign M_AXI_awvalid  = aw_valid_q;
  assign M_AXI_arid     = id_q;
  assign M_AXI_araddr   = addr_q;
  assign M_AXI_arlen    = len_q;
  assign M_AXI_arsize   = AX_SIZE;
  assign M_AXI_arburst  = 2'b01;
  assign M_AXI_arlock   = 1'b0;
  assign M_AXI_arcache  = 4'd0;
  assign M_AXI_arprot   = 3'd0;
  assign M_AXI_arqos    = 4'd0;
  assign M_AXI_arregion = 4'd0;
  assign M_AXI_arvalid  = ar_valid_q;
  assign M_AXI_wdata    = wr_data;
  assign M_AXI_wstrb    = wr_strb;
  assign rd_data        = M_AXI_rdata;
  assign rd_last        = M_AXI_rlast;
  assign done_write     = write_q;
  assign done_resp      = resp_q;
  assign done_err       = err_q;

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and the channel handshakes that pass straight through
  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    wr_ready      = 1'b0;
    M_AXI_wvalid  = 1'b0;
    M_AXI_wlast   = 1'b0;
    M_AXI_bready  = 1'b0;
    M_AXI_rready  = 1'b0;
    rd_valid      = 1'b0;
    done_valid    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = cmd_write ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: if (aw_valid_q && M_AXI_awready) state_next = WR_DATA;
      WR_DATA: begin
        M_AXI_wvalid = wr_valid;
        wr_ready     = M_AXI_wready;
        M_AXI_wlast  = last_beat;
        if (wr_valid && M_AXI_wready && last_beat) state_next = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_bready = 1'b1;
        if (M_AXI_bvalid) state_next = DONE;
      end
      RD_ADDR: if (ar_valid_q && M_AXI_arready) state_next = RD_DATA;
      RD_DATA: begin
        rd_valid     = M_AXI_rvalid;
        M_AXI_rready = rd_ready;
        if (M_AXI_rvalid && rd_ready && M_AXI_rlast) state_next = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, address valids, beat counter and response/error tracking
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q     <= '0;
      len_q      <= 8'd0;
      id_q       <= '0;
      write_q    <= 1'b0;
      aw_valid_q <= 1'b0;
      ar_valid_q <= 1'b0;
      beat_cnt   <= 8'd0;
      resp_q     <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        addr_q     <= cmd_addr;
        len_q      <= cmd_len;
        id_q       <= cmd_id;
        write_q    <= cmd_write;
        aw_valid_q <= cmd_write;
        ar_valid_q <= !cmd_write;
        beat_cnt   <= 8'd0;
        resp_q     <= 2'b00;
        err_q      <= 1'b0;
      end
      if (aw_valid_q && M_AXI_awready) aw_valid_q <= 1'b0;
      if (ar_valid_q && M_AXI_arready) ar_valid_q <= 1'b0;
      if (state == WR_DATA && wr_valid && M_AXI_wready) beat_cnt <= beat_cnt + 8'd1;
      if (state == WR_RESP && M_AXI_bvalid) resp_q <= M_AXI_bresp;
      if (state == RD_DATA && M_AXI_rvalid && rd_ready) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (M_AXI_rresp > resp_q) resp_q <= M_AXI_rresp;
        // Early RLAST or a missing RLAST on the final counted beat both flag an error.
        if (M_AXI_rlast != last_beat) err_q <= 1'b1;
      end
    end
  end

`ifdef AXI_MASTER_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  // Saturating completion counters, updated on the done cycle
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stat_wr_bursts <= '0;
      stat_rd_bursts <= '0;
      stat_err       <= '0;
    end else if (state == DONE) begin
      if (write_q && stat_wr_bursts != STAT_MAX)
        stat_wr_bursts <= stat_wr_bursts + STAT_WIDTH'(1);
      if (!write_q && stat_rd_bursts != STAT_MAX)
        stat_rd_bursts <= stat_rd_bursts + STAT_WIDTH'(1);
      if ((resp_q != 2'b00 || err_q) && stat_err != STAT_MAX)
        stat_err <= stat_err + STAT_WIDTH'(1);
    end
  end
`else
  logic [STAT_WIDTH-1:0] unused_stat;
  assign unused_stat = '0;
`endif

endmodule

// File: tb/tb_axi_memory_master.sv
// tb/tb_axi_memory_master.sv - directed vector bench for axi_memory_master (stats checked when AXI_MASTER_STATS_EN is set)
module tb_axi_memory_master;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done_valid, done_write, done_err;
  logic [1:0]  done_resp;
  logic [3:0]  M_AXI_awid, M_AXI_awcache, M_AXI_awqos, M_AXI_awregion;
  logic [31:0] M_AXI_awaddr;
  logic [7:0]  M_AXI_awlen;
  logic [2:0]  M_AXI_awsize, M_AXI_awprot;
  logic [1:0]  M_AXI_awburst;
  logic        M_AXI_awlock, M_AXI_awvalid, M_AXI_awready;
  logic [31:0] M_AXI_wdata;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_wlast, M_AXI_wvalid, M_AXI_wready;
  logic [3:0]  M_AXI_bid;
  logic [1:0]  M_AXI_bresp;
  logic        M_AXI_bvalid, M_AXI_bready;
  logic [3:0]  M_AXI_arid, M_AXI_arcache, M_AXI_arqos, M_AXI_arregion;
  logic [31:0] M_AXI_araddr;
  logic [7:0]  M_AXI_arlen;
  logic [2:0]  M_AXI_arsize, M_AXI_arprot;
  logic [1:0]  M_AXI_arburst;
  logic        M_AXI_arlock, M_AXI_arvalid, M_AXI_arready;
  logic [3:0]  M_AXI_rid;
  logic [31:0] M_AXI_rdata;
  logic [1:0]  M_AXI_rresp;
  logic        M_AXI_rlast, M_AXI_rvalid, M_AXI_rready;
`ifdef AXI_MASTER_STATS_EN
  logic [15:0] stat_wr_bursts, stat_rd_bursts, stat_err;
`endif

  axi_memory_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_write(done_write), .done_resp(done_resp), .done_err(done_err),
    .M_AXI_awid(M_AXI_awid), .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen),
    .M_AXI_awsize(M_AXI_awsize), .M_AXI_awburst(M_AXI_awburst), .M_AXI_awlock(M_AXI_awlock),
    .M_AXI_awcache(M_AXI_awcache), .M_AXI_awprot(M_AXI_awprot), .M_AXI_awqos(M_AXI_awqos),
    .M_AXI_awregion(M_AXI_awregion), .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bid(M_AXI_bid), .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
    .M_AXI_arid(M_AXI_arid), .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen),
    .M_AXI_arsize(M_AXI_arsize), .M_AXI_arburst(M_AXI_arburst), .M_AXI_arlock(M_AXI_arlock),
    .M_AXI_arcache(M_AXI_arcache), .M_AXI_arprot(M_AXI_arprot), .M_AXI_arqos(M_AXI_arqos),
    .M_AXI_arregion(M_AXI_arregion), .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rid(M_AXI_rid), .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
    .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
`ifdef AXI_MASTER_STATS_EN
    ,
    .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts), .stat_err(stat_err)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    logic [31:0] base;       // data of beat n is base + n
    int          delay;      // cycles AW/AR ready is withheld
    bit          toggle;     // rd_ready alternates 1/0
    int          resp_beat;  // read beat carrying resp_val (-1: none)
    logic [1:0]  resp_val;   // also used as BRESP for writes
    int          rlast_beat; // read beat on which the slave raises RLAST
    int          abort_beat; // write beat during which ARESET is pulsed (-1: none)
    logic [1:0]  exp_resp;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [0:10];
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          exp_wr = 0, exp_rd = 0, exp_se = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    M_AXI_awready = 1'b0; M_AXI_wready = 1'b0; M_AXI_arready = 1'b0;
    M_AXI_bid = '0; M_AXI_bresp = '0; M_AXI_bvalid = 1'b0;
    M_AXI_rid = '0; M_AXI_rdata = '0; M_AXI_rresp = '0; M_AXI_rlast = 1'b0; M_AXI_rvalid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_awvalid"}, M_AXI_awvalid, 0);
    chk({tag, "_arvalid"}, M_AXI_arvalid, 0);
    chk({tag, "_wvalid"}, M_AXI_wvalid, 0);
    chk({tag, "_bready"}, M_AXI_bready, 0);
    chk({tag, "_rready"}, M_AXI_rready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_done_valid"}, done_valid, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic do_vec(input int idx, input vec_t v);
    int  beat, waitc, word;
    bit  addr_done, data_done, stop, aborted;
    string t;
    t = $sformatf("v%0d", idx);
    word = int'(v.addr[11:2]);
    beat = 0; waitc = 0; addr_done = 0; data_done = 0; stop = 0; aborted = 0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = 8'(v.len); cmd_id = 4'h5;
    #1 chk({t, "_cmd_ready"}, cmd_ready, 1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && !stop; cyc++) begin
      M_AXI_awready = !addr_done && v.wr && (waitc >= v.delay);
      M_AXI_arready = !addr_done && !v.wr && (waitc >= v.delay);
      M_AXI_wready  = v.wr && addr_done && !data_done;
      wr_valid      = M_AXI_wready;
      wr_data       = v.base + 32'(beat);
      wr_strb       = 4'hF;
      M_AXI_bvalid  = v.wr && data_done;
      M_AXI_bresp   = v.resp_val;
      M_AXI_bid     = 4'h5;
      M_AXI_rvalid  = !v.wr && addr_done && !data_done;
      M_AXI_rdata   = mem[word + beat];
      M_AXI_rresp   = (beat == v.resp_beat) ? v.resp_val : 2'b00;
      M_AXI_rlast   = (beat == v.rlast_beat);
      M_AXI_rid     = 4'h5;
      rd_ready      = v.toggle ? (cyc % 2 == 0) : 1'b1;
      if (v.wr && addr_done && !data_done && beat == v.abort_beat) ARESET = 1'b1;
      #1;
      if (ARESET) begin
        aborted = 1; stop = 1;
      end else if (!addr_done) begin
        chk({t, "_no_w_before_aw"}, M_AXI_wvalid, 0);
        if (v.wr) begin
          chk({t, "_awvalid_held"}, M_AXI_awvalid, 1);
          chk({t, "_arvalid_off"}, M_AXI_arvalid, 0);
          if (waitc == 0) begin
            chk({t, "_awaddr"}, M_AXI_awaddr, v.addr);
            chk({t, "_awlen"}, M_AXI_awlen, 64'(v.len));
            chk({t, "_awsize"}, M_AXI_awsize, 2);
            chk({t, "_awburst"}, M_AXI_awburst, 1);
            chk({t, "_awid"}, M_AXI_awid, 5);
          end
        end else begin
          chk({t, "_arvalid_held"}, M_AXI_arvalid, 1);
          chk({t, "_awvalid_off"}, M_AXI_awvalid, 0);
          if (waitc == 0) begin
            chk({t, "_araddr"}, M_AXI_araddr, v.addr);
            chk({t, "_arlen"}, M_AXI_arlen, 64'(v.len));
            chk({t, "_arsize"}, M_AXI_arsize, 2);
            chk({t, "_arburst"}, M_AXI_arburst, 1);
          end
        end
        if (M_AXI_awready || M_AXI_arready) addr_done = 1;
        waitc++;
      end else if (v.wr && !data_done) begin
        chk({t, "_wvalid"}, M_AXI_wvalid, 1);
        chk({t, "_wr_ready"}, wr_ready, 1);
        chk({t, "_wdata"}, M_AXI_wdata, v.base + 32'(beat));
        chk({t, "_wlast"}, M_AXI_wlast, beat == v.len);
        mem[word + beat] = M_AXI_wdata;
        if (beat == v.len) data_done = 1;
        beat++;
      end else if (v.wr) begin
        chk({t, "_bready"}, M_AXI_bready, 1);
        stop = 1;
      end else begin
        chk({t, "_rd_valid"}, rd_valid, 1);
        chk({t, "_rready_follows"}, M_AXI_rready, rd_ready);
        if (rd_ready) begin
          chk({t, "_rd_data"}, rd_data, v.base + 32'(beat));
          chk({t, "_rd_last"}, rd_last, beat == v.rlast_beat);
          if (M_AXI_rlast) begin
            data_done = 1; stop = 1;
          end
          beat++;
        end
      end
      @(negedge ACLK);
    end
    idle_inputs();
    if (!stop) begin
      errors++;
      $display("FAIL %s_timeout: burst did not complete within 200 cycles", t);
    end else if (aborted) begin
      #1 check_quiet({t, "_after_reset"});
      ARESET = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge ACLK);
        #1 chk({t, "_no_done_after_reset"}, done_valid, 0);
      end
    end else begin
      #1;
      chk({t, "_done_valid"}, done_valid, 1);
      chk({t, "_done_write"}, done_write, v.wr);
      chk({t, "_done_resp"}, done_resp, v.exp_resp);
      chk({t, "_done_err"}, done_err, v.exp_err);
      chk({t, "_cmd_ready_in_done"}, cmd_ready, 0);
      @(negedge ACLK);
      #1;
      chk({t, "_done_pulse_len"}, done_valid, 0);
      chk({t, "_cmd_ready_back"}, cmd_ready, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    //          wr  addr        len base      dly tog rbeat rval   rlast abort exp_r  err
    vecs[0]  = '{1, 32'h100, 3, 32'hA0, 0, 0, -1, 2'b00, 3, -1, 2'b00, 0};
    vecs[1]  = '{0, 32'h100, 3, 32'hA0, 0, 0, -1, 2'b00, 3, -1, 2'b00, 0};
    vecs[2]  = '{0, 32'h100, 0, 32'hA0, 3, 1, -1, 2'b00, 0, -1, 2'b00, 0};
    vecs[3]  = '{1, 32'h200, 1, 32'hB0, 1, 0, -1, 2'b00, 1, -1, 2'b00, 0};
    vecs[4]  = '{0, 32'h200, 1, 32'hB0, 0, 0,  1, 2'b10, 1, -1, 2'b10, 0};
    vecs[5]  = '{0, 32'h100, 3, 32'hA0, 0, 0, -1, 2'b00, 1, -1, 2'b00, 1};
    vecs[6]  = '{1, 32'h300, 3, 32'hC0, 0, 0, -1, 2'b00, 3,  2, 2'b00, 0};
    vecs[7]  = '{1, 32'h300, 3, 32'hD0, 0, 0, -1, 2'b00, 3, -1, 2'b00, 0};
    vecs[8]  = '{0, 32'h300, 3, 32'hD0, 2, 1, -1, 2'b00, 3, -1, 2'b00, 0};
    vecs[9]  = '{1, 32'h400, 0, 32'hE0, 0, 0, -1, 2'b11, 0, -1, 2'b11, 0};
    vecs[10] = '{0, 32'h100, 1, 32'hA0, 0, 0, -1, 2'b00, 2, -1, 2'b00, 1};

    idle_inputs();
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    #1;
    check_quiet("reset");
    chk("reset_done_resp", done_resp, 0);
    chk("reset_done_err", done_err, 0);
    chk("reset_wr_ready", wr_ready, 0);
    ARESET = 1'b0;

    for (int i = 0; i <= 10; i++) begin
      do_vec(i, vecs[i]);
      if (vecs[i].abort_beat < 0) begin
        if (vecs[i].wr) exp_wr++;
        else            exp_rd++;
        if (vecs[i].exp_resp != 2'b00 || vecs[i].exp_err) exp_se++;
      end
`ifdef AXI_MASTER_STATS_EN
      chk($sformatf("v%0d_stat_wr", i), stat_wr_bursts, exp_wr);
      chk($sformatf("v%0d_stat_rd", i), stat_rd_bursts, exp_rd);
      chk($sformatf("v%0d_stat_err", i), stat_err, exp_se);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
